// File: rtl/wr_bridge_pkg.sv
// Shared definitions for the write-bridge arbiter: FSM encoding, timeout
// response word, bridge address map and the request bundle carried to the bridge.
package wr_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

   localparam logic [8:0] ADDR_UART_DATA   = 9'h020;
   localparam logic [8:0] ADDR_UART_STATUS = 9'h028;
   localparam logic [8:0] ADDR_FIFO_WRITE  = 9'h100;
   localparam logic [8:0] ADDR_FIFO_STATUS = 9'h144;

   // One master's request as it is latched onto the bridge.
   typedef struct packed {
      logic        read;
      logic        write;
      logic [3:0]  byte_enable;
      logic [8:0]  address;
      logic [31:0] write_data;
   } bus_req_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/wr_bridge_watchdog.sv
// Down-counting watchdog: load on issue, count while enabled, expired flags
// the last allowed cycle of a transaction.
module wr_bridge_watchdog #(
   parameter int unsigned CYCLES = 1023
) (
   input  logic clock,
   input  logic nreset,
   input  logic load,
   input  logic enable,
   output logic expired
);

   // Loaded with CYCLES-1 so that expired rises on the CYCLES-th enabled cycle.
   localparam logic [15:0] LOAD_VALUE = 16'(CYCLES - 1);

   logic [15:0] count_reg;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= LOAD_VALUE;
      end else if (enable && (count_reg != 16'd0)) begin
         count_reg <= count_reg - 16'd1;
      end
   end

   assign expired = (count_reg == 16'd0);

endmodule

// File: rtl/wr_bridge_arbiter.sv
// Two-master arbiter in front of a single request/acknowledge bridge, with
// round-robin tie-break, ack watchdog and sticky timeout status.
module wr_bridge_arbiter
   import wr_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
   input  logic        clock,
   input  logic        nreset,

   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [3:0]  m0_byte_enable,
   input  logic [8:0]  m0_address,
   input  logic [31:0] m0_write_data,
   output logic [31:0] m0_read_data,
   output logic        m0_acknowledge,

   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [3:0]  m1_byte_enable,
   input  logic [8:0]  m1_address,
   input  logic [31:0] m1_write_data,
   output logic [31:0] m1_read_data,
   output logic        m1_acknowledge,

   output logic        s_read,
   output logic        s_write,
   output logic [3:0]  s_byte_enable,
   output logic [8:0]  s_address,
   output logic [31:0] s_write_data,
   input  logic [31:0] s_read_data,
   input  logic        s_acknowledge,

   output logic [1:0]  grant,
   output logic        timeout_error,
   output logic [15:0] timeout_count,
   input  logic        clear_error
);

   state_t      state_reg, state_next;
   logic        last_m1_reg, last_m1_next;
   logic [1:0]  grant_reg, grant_next;
   logic        s_read_reg, s_read_next;
   logic        s_write_reg, s_write_next;
   logic [3:0]  s_byte_enable_reg, s_byte_enable_next;
   logic [8:0]  s_address_reg, s_address_next;
   logic [31:0] s_write_data_reg, s_write_data_next;
   logic [31:0] m0_read_data_reg, m0_read_data_next;
   logic [31:0] m1_read_data_reg, m1_read_data_next;
   logic        m0_ack_reg, m0_ack_next;
   logic        m1_ack_reg, m1_ack_next;
   logic        timeout_error_reg, timeout_error_next;
   logic [15:0] timeout_count_reg, timeout_count_next;

   logic        watchdog_load;
   logic        watchdog_enable;
   logic        watchdog_expired;

   bus_req_t    m0_bus, m1_bus, chosen_bus;
   logic        m0_request, m1_request, pick_m1;
   logic [31:0] response_data;

   assign m0_bus = '{read: m0_read, write: m0_write, byte_enable: m0_byte_enable,
                     address: m0_address, write_data: m0_write_data};
   assign m1_bus = '{read: m1_read, write: m1_write, byte_enable: m1_byte_enable,
                     address: m1_address, write_data: m1_write_data};

   assign m0_request = m0_read | m0_write;
   assign m1_request = m1_read | m1_write;

   // m1 wins only when alone, or on a tie when m0 owned the bus last time.
   assign pick_m1    = m1_request & (~m0_request | ~last_m1_reg);
   assign chosen_bus = pick_m1 ? m1_bus : m0_bus;

   // An ack on the expiry cycle still returns real data.
   assign response_data = s_acknowledge ? s_read_data : TIMEOUT_DATA;

   assign watchdog_enable = (state_reg == ISSUE);

   wr_bridge_watchdog #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .nreset  (nreset),
      .load    (watchdog_load),
      .enable  (watchdog_enable),
      .expired (watchdog_expired)
   );

   always_comb begin
      state_next         = state_reg;
      last_m1_next       = last_m1_reg;
      grant_next         = grant_reg;
      s_read_next        = s_read_reg;
      s_write_next       = s_write_reg;
      s_byte_enable_next = s_byte_enable_reg;
      s_address_next     = s_address_reg;
      s_write_data_next  = s_write_data_reg;
      m0_read_data_next  = m0_read_data_reg;
      m1_read_data_next  = m1_read_data_reg;
      m0_ack_next        = 1'b0;
      m1_ack_next        = 1'b0;
      timeout_error_next = timeout_error_reg;
      timeout_count_next = timeout_count_reg;
      watchdog_load      = 1'b0;

      if (clear_error) begin
         timeout_error_next = 1'b0;
         timeout_count_next = 16'd0;
      end

      case (state_reg)
         IDLE: begin
            grant_next = 2'b00;
            if (m0_request || m1_request) begin
               // Write takes precedence when a master raises both strobes.
               s_write_next       = chosen_bus.write;
               s_read_next        = chosen_bus.read & ~chosen_bus.write;
               s_byte_enable_next = chosen_bus.byte_enable;
               s_address_next     = chosen_bus.address;
               s_write_data_next  = chosen_bus.write_data;
               grant_next         = pick_m1 ? 2'b10 : 2'b01;
               last_m1_next       = pick_m1;
               watchdog_load      = 1'b1;
               state_next         = ISSUE;
            end
         end

         ISSUE: begin
            if (s_acknowledge || watchdog_expired) begin
               s_read_next        = 1'b0;
               s_write_next       = 1'b0;
               s_byte_enable_next = 4'h0;
               if (grant_reg[1]) begin
                  m1_read_data_next = response_data;
                  m1_ack_next       = 1'b1;
               end else begin
                  m0_read_data_next = response_data;
                  m0_ack_next       = 1'b1;
               end
               if (!s_acknowledge) begin
                  timeout_error_next = 1'b1;
                  timeout_count_next = clear_error ? 16'd1 : sat_inc16(timeout_count_reg);
               end
               state_next = RESPOND;
            end
         end

         RESPOND: begin
            state_next = RELEASE;
         end

         RELEASE: begin
            grant_next = 2'b00;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_reg         <= IDLE;
         last_m1_reg       <= 1'b1;
         grant_reg         <= 2'b00;
         s_read_reg        <= 1'b0;
         s_write_reg       <= 1'b0;
         s_byte_enable_reg <= 4'h0;
         s_address_reg     <= 9'h000;
         s_write_data_reg  <= 32'h0;
         m0_read_data_reg  <= 32'h0;
         m1_read_data_reg  <= 32'h0;
         m0_ack_reg        <= 1'b0;
         m1_ack_reg        <= 1'b0;
         timeout_error_reg <= 1'b0;
         timeout_count_reg <= 16'h0;
      end else begin
         state_reg         <= state_next;
         last_m1_reg       <= last_m1_next;
         grant_reg         <= grant_next;
         s_read_reg        <= s_read_next;
         s_write_reg       <= s_write_next;
         s_byte_enable_reg <= s_byte_enable_next;
         s_address_reg     <= s_address_next;
         s_write_data_reg  <= s_write_data_next;
         m0_read_data_reg  <= m0_read_data_next;
         m1_read_data_reg  <= m1_read_data_next;
         m0_ack_reg        <= m0_ack_next;
         m1_ack_reg        <= m1_ack_next;
         timeout_error_reg <= timeout_error_next;
         timeout_count_reg <= timeout_count_next;
      end
   end

   assign grant          = grant_reg;
   assign s_read         = s_read_reg;
   assign s_write        = s_write_reg;
   assign s_byte_enable  = s_byte_enable_reg;
   assign s_address      = s_address_reg;
   assign s_write_data   = s_write_data_reg;
   assign m0_read_data   = m0_read_data_reg;
   assign m1_read_data   = m1_read_data_reg;
   assign m0_acknowledge = m0_ack_reg;
   assign m1_acknowledge = m1_ack_reg;
   assign timeout_error  = timeout_error_reg;
   assign timeout_count  = timeout_count_reg;

endmodule

// File: doc/wr_bridge_arbiter.md
WR_BRIDGE_ARBITER -- requirements
Module: wr_bridge_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning slave-ack wait limit in clocks (range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'hDEAD_BEEF, meaning read data returned on timeout.
REQ-003 SHALL have ports: clock  in  1  clock, rising edge; nreset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have m0 (WR monitor) ports: m0_read in 1; m0_write in 1; m0_byte_enable in 4; m0_address in 9; m0_write_data in 32; m0_read_data out 32; m0_acknowledge out 1.
REQ-005 SHALL have m1 (IPbus host) ports, same names, directions and widths as m0 with prefix m1_.
REQ-006 SHALL have bridge ports: s_read out 1; s_write out 1; s_byte_enable out 4; s_address out 9; s_write_data out 32; s_read_data in 32; s_acknowledge in 1.
REQ-007 SHALL have status ports: grant out 2, one-hot owner (00 idle); timeout_error out 1, sticky; timeout_count out 16, saturating; clear_error in 1, synchronous pulse.

Function
REQ-008 SHALL register every output; no input-to-output combinational path.
REQ-009 SHALL use FSM states IDLE, ISSUE, RESPOND, RELEASE.
REQ-010 IDLE: master requests when its read or write is high; none -> stay IDLE, grant=00.
REQ-011 IDLE, single requester -> latch its address, byte_enable, write_data, op into bridge outputs, set grant, go ISSUE.
REQ-012 IDLE, both requesting same cycle -> grant master not granted last; after reset m0 wins first.
REQ-013 Master with read and write both high -> write issued, read ignored.
REQ-014 ISSUE: hold s_read/s_write and bus fields stable until s_acknowledge or timeout.
REQ-015 Latency: request in IDLE at cycle n -> s_read/s_write high at n+1.
REQ-016 ISSUE, s_acknowledge at cycle k -> at k+1 strobes and s_byte_enable low, granted mX_acknowledge high one cycle, mX_read_data = s_read_data sampled at k; state RESPOND.
REQ-017 ISSUE, no ack after TIMEOUT_CYCLES clocks -> strobes low, mX_acknowledge pulsed, mX_read_data = TIMEOUT_DATA, timeout_error set, timeout_count incremented (saturates at 16'hFFFF); state RESPOND.
REQ-018 Ack arriving on the cycle the timeout expires SHALL count as success.
REQ-019 RESPOND -> RELEASE unconditionally; RELEASE -> IDLE, grant=00, requests ignored in both (masters drop strobes one cycle after ack).
REQ-020 Non-granted master SHALL see acknowledge 0; its read_data SHALL hold its last value.
REQ-021 s_acknowledge outside ISSUE SHALL be ignored.
REQ-022 clear_error clears timeout_error and timeout_count next cycle; simultaneous timeout wins (error=1, count=1).
REQ-023 Minimum transaction period SHALL be 4 clocks (IDLE, ISSUE, RESPOND, RELEASE).

Reset
REQ-024 nreset low SHALL asynchronously force IDLE, all strobes, byte_enables, addresses, data, acknowledges, grant, timeout_error, timeout_count to 0, last-grant to m1 (so m0 wins first).
REQ-025 Reset mid-ISSUE SHALL drop bridge strobes immediately without master acknowledge; bridge-side recovery is the bridge's responsibility.

Structure
REQ-026 State encodings, TIMEOUT_DATA default and bridge address map (UART status 9'h28, UART data 9'h20, FIFO write 9'h100, FIFO status 9'h144) SHALL live in shared package wr_bridge_pkg.
REQ-027 Timeout counter MAY be sub-module wr_bridge_watchdog (load, enable, expired); the rest SHALL be flat.
REQ-028 RTL SHALL be 120-400 lines, one clock domain.

Verification
REQ-029 m0 read 9'h28, slave acks after 3 cycles with 32'h0000_0080 -> s_read high 3 cycles, m0_acknowledge one pulse, m0_read_data=32'h80, grant=01.
REQ-030 m0 and m1 request same cycle, twice in a row -> first grant m0, second m1, third (m0 re-requests) m0.
REQ-031 m1 write 9'h100 data 32'h0D0A_1234 be 4'hF, no slave ack -> ack after 1023 cycles, m1_read_data=32'hDEADBEEF, timeout_error=1, timeout_count=1; clear_error -> both 0.
REQ-032 m0 read and write both high -> s_write=1, s_read=0.
REQ-033 nreset low during ISSUE -> all outputs 0 within same cycle, no acknowledge; after release m0 request served normally.
REQ-034 Spurious s_acknowledge in IDLE -> no master acknowledge, state stays IDLE.
